// File: rtl/write_addr_burst_gen_pkg.sv
// rtl/write_addr_burst_gen_pkg.sv - shared burst/state encodings for the AW burst generator
package write_addr_burst_gen_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/write_addr_burst_gen_if.sv
// rtl/write_addr_burst_gen_if.sv - AW channel in, per-beat address stream out
interface write_addr_burst_gen_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_valid;
  logic              beat_ready;
  logic              beat_last;
  logic              beat_err;
  logic              burst_done;
  logic              burst_err;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, beat_ready,
    output awready, beat_addr, beat_valid, beat_last, beat_err, burst_done, burst_err
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, beat_ready,
    input  awready, beat_addr, beat_valid, beat_last, beat_err, burst_done, burst_err
  );
endinterface

// File: rtl/write_addr_burst_gen_axi_next_addr.sv
// rtl/write_addr_burst_gen_axi_next_addr.sv - combinational AXI next-beat address (FIXED/INCR/WRAP)
module axi_next_addr
  import write_addr_burst_gen_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] wrap_len;
  logic [ADDR_W-1:0] boundary;
  logic [ADDR_W-1:0] wrap_off;

  always_comb begin
    bytes    = ADDR_W'(1) << size;
    wrap_len = bytes * (ADDR_W'(len) + ADDR_W'(1));
    boundary = start_addr & ~(wrap_len - ADDR_W'(1));
    wrap_off = (wrap_len == '0) ? '0 : (addr + bytes - boundary) % wrap_len;
    // reserved encoding falls through to INCR; legality is judged upstream
    case (burst_e'(burst))
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = boundary + wrap_off;
      default:     next_addr = (addr & ~(bytes - ADDR_W'(1))) + bytes;
    endcase
  end

endmodule

// File: rtl/write_addr_burst_gen.sv
// rtl/write_addr_burst_gen.sv - AXI4 AW burst expander with MEM_TOP window check
// Optional protocol legality checks enabled by WADDR_PROTOCOL_CHECK_EN.
module write_addr_burst_gen
  import write_addr_burst_gen_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] MEM_TOP = ADDR_W'('h3FFF)
`ifdef WADDR_PROTOCOL_CHECK_EN
  , parameter int              BUS_BYTES_LOG2 = 2
`endif
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  write_addr_burst_gen_if.slave bus
);

  state_e            state;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        len;
  logic [7:0]        cnt;
  logic [2:0]        size;
  logic [1:0]        burst;
  logic              illegal;
  logic              illegal_in;
  logic              awready;
  logic              beat_valid;
  logic              beat_last;
  logic              beat_err;
  logic              burst_done;
  logic              burst_err;

`ifdef WADDR_PROTOCOL_CHECK_EN
  logic [ADDR_W-1:0] aw_bytes;
  assign aw_bytes   = ADDR_W'(1) << bus.awsize;
  assign illegal_in = (bus.awburst == BURST_RSVD)
                    || (bus.awsize > 3'(BUS_BYTES_LOG2))
                    || ((bus.awburst == BURST_WRAP) && !wrap_len_ok(bus.awlen))
                    || ((bus.awburst == BURST_WRAP) && ((bus.awaddr & (aw_bytes - ADDR_W'(1))) != '0));
`else
  assign illegal_in = 1'b0;
`endif

  axi_next_addr #(.ADDR_W(ADDR_W)) u_next_addr (
    .addr       (beat_addr),
    .start_addr (start_addr),
    .size       (size),
    .len        (len),
    .burst      (burst),
    .next_addr  (next_addr)
  );

  // gated by beat_valid so a stale out-of-window address does not flag between bursts
  assign beat_err = beat_valid && ((beat_addr > MEM_TOP) || illegal);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      start_addr <= '0;
      beat_addr  <= '0;
      len        <= '0;
      cnt        <= '0;
      size       <= '0;
      burst      <= '0;
      illegal    <= 1'b0;
      awready    <= 1'b0;
      beat_valid <= 1'b0;
      beat_last  <= 1'b0;
      burst_done <= 1'b0;
      burst_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.awvalid && awready) begin
            start_addr <= bus.awaddr;
            beat_addr  <= bus.awaddr;
            len        <= bus.awlen;
            cnt        <= bus.awlen;
            size       <= bus.awsize;
            burst      <= bus.awburst;
            illegal    <= illegal_in;
            awready    <= 1'b0;
            beat_valid <= 1'b1;
            beat_last  <= (bus.awlen == 8'd0);
            state      <= ST_BURST;
          end else begin
            awready <= 1'b1;
          end
        end
        ST_BURST: begin
          if (beat_valid && bus.beat_ready) begin
            burst_err <= burst_err | beat_err;
            if (beat_last) begin
              beat_valid <= 1'b0;
              beat_last  <= 1'b0;
              burst_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              beat_addr <= next_addr;
              cnt       <= cnt - 8'd1;
              beat_last <= (cnt == 8'd1);
            end
          end
        end
        ST_DONE: begin
          // awready is raised here so it is visible on the first IDLE cycle
          burst_done <= 1'b0;
          burst_err  <= 1'b0;
          awready    <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.awready    = awready;
  assign bus.beat_addr  = beat_addr;
  assign bus.beat_valid = beat_valid;
  assign bus.beat_last  = beat_last;
  assign bus.beat_err   = beat_err;
  assign bus.burst_done = burst_done;
  assign bus.burst_err  = burst_err;

endmodule
